bit_balance_mon: RTL and testbench

Parametrised successor to the byte-stream ones/zeros counter. It accepts a DATA_W-bit word stream with a valid qualifier and splits it into fixed windows of WINDOW_WORDS accepted words. For each window it reports the ones count, the zeros count and the absolute imbalance. It compares the imbalance against a runtime threshold and keeps a window counter and a saturating imbalance-error counter. It sits on the monitored data path as a passive observer and never back-pressures.

---
 rtl/bit_balance_mon.sv | 189 ++++++++++++++++++
 tb/tb_bit_balance_mon.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_balance_mon.sv
// bit_balance_mon: passive observer of a DATA_W-bit word stream.
// The stream is cut into windows of WINDOW_WORDS accepted words. For each
// window the block reports the ones count, the zeros count and the absolute
// imbalance, and flags windows whose imbalance exceeds a runtime threshold.
// It also counts completed windows (wrapping) and flagged windows (saturating).
// Pipeline: popcount register -> accumulator/sum latch -> result registers.
// The result appears two edges after the window's final word is accepted.
module bit_balance_mon #(
  parameter int DATA_W       = 8,
  parameter int WINDOW_WORDS = 32,
  parameter int CNT_W        = $clog2(DATA_W * WINDOW_WORDS + 1),
  parameter int WIN_W        = 16,
  parameter int ERR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  imb_thr,
  output logic              res_valid,
  output logic [CNT_W-1:0]  ones,
  output logic [CNT_W-1:0]  zeros,
  output logic [CNT_W-1:0]  imbalance,
  output logic              imb_flag,
  output logic [WIN_W-1:0]  win_cnt,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int WINDOW_BITS = DATA_W * WINDOW_WORDS;
  localparam int POP_W       = $clog2(DATA_W + 1);
  localparam int WC_W        = $clog2(WINDOW_WORDS);

  localparam logic [WC_W-1:0]  LAST_IDX = WC_W'(WINDOW_WORDS - 1);
  localparam logic [CNT_W-1:0] BITS_C   = CNT_W'(WINDOW_BITS);

  // Word position inside the current window.
  logic [WC_W-1:0]  r_word_cnt;

  // Stage 1: popcount of the accepted word with valid/last tags.
  logic             r_s1_valid;
  logic             r_s1_last;
  logic [POP_W-1:0] r_s1_pop;

  // Stage 2: running accumulator and the latched window sum.
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_sum;
  logic             r_s2_valid;

  // Stage 3: result registers driving the outputs.
  logic             r_res_valid;
  logic [CNT_W-1:0] r_ones;
  logic [CNT_W-1:0] r_zeros;
  logic [CNT_W-1:0] r_imbalance;
  logic             r_imb_flag;
  logic [WIN_W-1:0] r_win_cnt;
  logic [ERR_W-1:0] r_err_cnt;

  // Combinational helpers.
  logic             w_accept;
  logic             w_last;
  logic [POP_W-1:0] w_pop;
  logic [CNT_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_zeros;
  logic [CNT_W-1:0] w_imbalance;
  logic             w_flag;

  // A word counts only when valid and not being flushed in the same cycle.
  assign w_accept = in_valid & ~clear;
  assign w_last   = (r_word_cnt == LAST_IDX);

  // Popcount of the incoming word.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign a default first
    // so every path drives the signal and no latch is inferred.
    w_pop = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_pop = w_pop + POP_W'(in_data[i]);
    end
  end

  // Word counter: 0..WINDOW_WORDS-1 over accepted words, wraps after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // its inputs from before the edge, independent of statement order.
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (clear) begin
      r_word_cnt <= '0;
    end else if (w_accept) begin
      r_word_cnt <= w_last ? '0 : r_word_cnt + WC_W'(1);
    end
  end

  // Stage 1: register the popcount tagged with valid and last-of-window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pop   <= '0;
    end else if (clear) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_pop   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_accept & w_last;
      if (w_accept) begin
        r_s1_pop <= w_pop;
      end
    end
  end

  // The window sum never exceeds WINDOW_BITS, which CNT_W holds exactly.
  assign w_acc_next = r_acc + CNT_W'(r_s1_pop);

  // Stage 2: accumulate; on the last word latch the sum and restart at zero
  // in the same edge so a back-to-back window loses nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_sum      <= '0;
      r_s2_valid <= 1'b0;
    end else if (clear) begin
      r_acc      <= '0;
      r_sum      <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid & r_s1_last;
      if (r_s1_valid) begin
        if (r_s1_last) begin
          r_sum <= w_acc_next;
          r_acc <= '0;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  // Derived results: |ones - zeros| equals |2*ones - WINDOW_BITS|.
  always_comb begin
    w_zeros     = BITS_C - r_sum;
    w_imbalance = (r_sum >= w_zeros) ? (r_sum - w_zeros) : (w_zeros - r_sum);
    w_flag      = (w_imbalance > imb_thr);
  end

  // Stage 3: publish results and update the window/error counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_ones      <= '0;
      r_zeros     <= '0;
      r_imbalance <= '0;
      r_imb_flag  <= 1'b0;
      r_win_cnt   <= '0;
      r_err_cnt   <= '0;
    end else if (clear) begin
      r_res_valid <= 1'b0;
      r_ones      <= '0;
      r_zeros     <= '0;
      r_imbalance <= '0;
      r_imb_flag  <= 1'b0;
      r_win_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_res_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_ones      <= r_sum;
        r_zeros     <= w_zeros;
        r_imbalance <= w_imbalance;
        r_imb_flag  <= w_flag;
        r_win_cnt   <= r_win_cnt + WIN_W'(1);
        if (w_flag && (r_err_cnt != '1)) begin
          r_err_cnt <= r_err_cnt + ERR_W'(1);
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign ones      = r_ones;
  assign zeros     = r_zeros;
  assign imbalance = r_imbalance;
  assign imb_flag  = r_imb_flag;
  assign win_cnt   = r_win_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_bit_balance_mon.sv
// Directed bench for bit_balance_mon with DATA_W=8, WINDOW_WORDS=4
// (WINDOW_BITS=32, CNT_W=6), WIN_W=16, ERR_W=2.
// Inputs change and outputs are sampled 1 time unit after each falling edge.
module tb_bit_balance_mon;

  localparam int DATA_W = 8;
  localparam int WW     = 4;
  localparam int CNT_W  = 6;
  localparam int WIN_W  = 16;
  localparam int ERR_W  = 2;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              clear    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic [CNT_W-1:0]  imb_thr  = '0;
  logic              res_valid;
  logic [CNT_W-1:0]  ones;
  logic [CNT_W-1:0]  zeros;
  logic [CNT_W-1:0]  imbalance;
  logic              imb_flag;
  logic [WIN_W-1:0]  win_cnt;
  logic [ERR_W-1:0]  err_cnt;

  int checks    = 0;
  int errors    = 0;
  int pulse_cnt = 0;
  int pulse_base;

  bit_balance_mon #(
    .DATA_W      (DATA_W),
    .WINDOW_WORDS(WW),
    .CNT_W       (CNT_W),
    .WIN_W       (WIN_W),
    .ERR_W       (ERR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .imb_thr  (imb_thr),
    .res_valid(res_valid),
    .ones     (ones),
    .zeros    (zeros),
    .imbalance(imbalance),
    .imb_flag (imb_flag),
    .win_cnt  (win_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Count every res_valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (res_valid === 1'b1) pulse_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Synchronous flush with a valid word offered in the same cycle.
  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input logic rv, input int o, input int z,
                               input int imb, input logic flag, input int win, input int err);
    check({tag, ".res_valid"}, 32'(res_valid), 32'(rv));
    check({tag, ".ones"},      32'(ones),      32'(o));
    check({tag, ".zeros"},     32'(zeros),     32'(z));
    check({tag, ".imbalance"}, 32'(imbalance), 32'(imb));
    check({tag, ".imb_flag"},  32'(imb_flag),  32'(flag));
    check({tag, ".win_cnt"},   32'(win_cnt),   32'(win));
    check({tag, ".err_cnt"},   32'(err_cnt),   32'(err));
  endtask

  // Called right after the final word's edge E: no pulse at E+1, pulse with
  // results at E+2, results held and pulse gone at E+3.
  task automatic expect_window(input string tag, input int o, input int z, input int imb,
                               input logic flag, input int win, input int err);
    idle(1);
    check({tag, ".early"}, 32'(res_valid), 32'd0);
    idle(1);
    check_outputs(tag, 1'b1, o, z, imb, flag, win, err);
    idle(1);
    check_outputs({tag, ".hold"}, 1'b0, o, z, imb, flag, win, err);
  endtask

  initial begin
    // 1. Reset, then idle: all outputs zero and no pulse.
    step();
    step();
    check_outputs("reset", 1'b0, 0, 0, 0, 1'b0, 0, 0);
    rst_n = 1'b1;
    idle(5);
    check_outputs("idle", 1'b0, 0, 0, 0, 1'b0, 0, 0);
    check("idle.pulses", 32'(pulse_cnt), 32'd0);

    // 2. Balanced window: 8+0+4+4 = 16 ones.
    imb_thr = 6'd4;
    drive(8'hFF);
    drive(8'h00);
    drive(8'h0F);
    drive(8'hF0);
    expect_window("balanced", 16, 16, 0, 1'b0, 1, 0);

    // 3. All-ones windows; err_cnt saturates at 3 over five windows.
    do_clear();
    check_outputs("after_clear", 1'b0, 0, 0, 0, 1'b0, 0, 0);
    imb_thr = 6'd8;
    for (int k = 1; k <= 5; k++) begin
      repeat (WW) drive(8'hFF);
      expect_window($sformatf("all_ones%0d", k), 32, 0, 32, 1'b1, k, (k > 3) ? 3 : k);
    end

    // 4. Balanced window with bubbles, always at least one before the final word.
    do_clear();
    imb_thr = 6'd4;
    drive(8'hFF);
    idle($urandom_range(0, 3));
    drive(8'h00);
    idle($urandom_range(0, 3));
    drive(8'h0F);
    idle($urandom_range(1, 3));
    drive(8'hF0);
    expect_window("bubbles", 16, 16, 0, 1'b0, 1, 0);

    // 5. Back-to-back windows; threshold 16 makes the second window an
    //    exact-equality case that must not flag.
    do_clear();
    imb_thr    = 6'd16;
    pulse_base = pulse_cnt;
    repeat (WW) drive(8'h01);          // final word of window 1 at edge E1
    drive(8'h03);                      // E1+1
    check("b2b.w1_early", 32'(res_valid), 32'd0);
    drive(8'h03);                      // E1+2
    check_outputs("b2b.w1", 1'b1, 4, 28, 24, 1'b1, 1, 1);
    drive(8'h03);                      // E1+3
    check("b2b.w1_once", 32'(res_valid), 32'd0);
    drive(8'h03);                      // E1+4: final word of window 2
    check("b2b.gap", 32'(res_valid), 32'd0);
    expect_window("b2b.w2", 8, 24, 16, 1'b0, 2, 1);
    check("b2b.pulses", 32'(pulse_cnt - pulse_base), 32'd2);

    // In-flight result is dropped when clear lands one edge after the final word.
    do_clear();
    pulse_base = pulse_cnt;
    repeat (WW) drive(8'hFF);
    do_clear();
    idle(4);
    check("inflight_clear.pulses", 32'(pulse_cnt - pulse_base), 32'd0);
    check_outputs("inflight_clear", 1'b0, 0, 0, 0, 1'b0, 0, 0);

    // 6a. Clear mid-window discards the partial window.
    imb_thr    = 6'd4;
    pulse_base = pulse_cnt;
    drive(8'hFF);
    drive(8'hFF);
    do_clear();
    repeat (WW) drive(8'hAA);
    expect_window("mid_clear", 16, 16, 0, 1'b0, 1, 0);
    idle(3);
    check("mid_clear.pulses", 32'(pulse_cnt - pulse_base), 32'd1);

    // 6b. Asynchronous reset mid-window does the same.
    pulse_base = pulse_cnt;
    drive(8'hFF);
    drive(8'hFF);
    rst_n = 1'b0;
    step();
    check_outputs("mid_reset.low", 1'b0, 0, 0, 0, 1'b0, 0, 0);
    rst_n = 1'b1;
    repeat (WW) drive(8'hAA);
    expect_window("mid_reset", 16, 16, 0, 1'b0, 1, 0);
    idle(3);
    check("mid_reset.pulses", 32'(pulse_cnt - pulse_base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
